// File: rtl/reg_alu_seq.sv
// reg_alu_seq: instruction sequencer issuing register-file/ALU datapath control
// for immediate loads and single or repeated ALU operations, counting reported carries.
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        cout,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  carry_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WAIT, S_DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  carry_q, carry_d;
    logic        exec_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            instr_q <= 16'd0;
            cnt_q   <= 3'd0;
            carry_q <= 4'd0;
            exec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            exec_q  <= state_q == S_EXEC;
        end
    end
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        carry_d = (exec_q && cout && carry_q != 4'd8) ? carry_q + 4'd1 : carry_q;
        case (state_q)
            S_IDLE: if (instr_valid) begin
                instr_d = instr;
                cnt_d   = instr[2:0];
                carry_d = 4'd0;
                state_d = instr[15:14] == 2'b00 ? S_LOAD :
                          instr[15:14] == 2'b01 ? S_EXEC : S_DONE;
            end
            S_LOAD:  state_d = S_DONE;
            S_EXEC:  if (cnt_q == 3'd0) state_d = S_WAIT; else cnt_d = cnt_q - 3'd1;
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    // Every datapath control is zero unless a write is being issued.
    assign sel         = state_q == S_EXEC;
    assign wr          = sel || state_q == S_LOAD;
    assign op          = sel ? instr_q[13:12] : 2'd0;
    assign rd_addr_a   = sel ? instr_q[11:9] : 3'd0;
    assign rd_addr_b   = sel ? instr_q[8:6] : 3'd0;
    assign wr_addr     = sel ? instr_q[5:3] : state_q == S_LOAD ? instr_q[13:11] : 3'd0;
    assign d_in        = state_q == S_LOAD ? {5'b0, instr_q[10:0]} : 16'd0;
    assign instr_ready = state_q == S_IDLE;
    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign carry_cnt   = carry_q;
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: table vectors, hand sequences and random instructions against a cycle-schedule model.
module tb_reg_alu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'd0;
    logic        cout = 1'b0;
    logic        instr_ready, sel, wr, busy, done;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in;
    logic [3:0]  carry_cnt;
    int checks = 0;
    int failures = 0;

    reg_alu_seq dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .cout(cout), .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .d_in(d_in), .busy(busy), .done(done), .carry_cnt(carry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    // mask bit k = cout driven during cycle k after the accept edge
    typedef struct {
        logic [15:0] instr;
        logic [15:0] mask;
        int          wr_n;
        int          dc;
        logic [3:0]  carry;
        logic        sel;
        logic [1:0]  op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
        logic [15:0] din;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [15:0] in, input logic [15:0] mask);
        vec_t v;
        int   n;
        int   c;
        v = '{in, mask, 0, 1, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd0};
        if (in[15:14] == 2'b00) begin
            v.wr_n = 1; v.dc = 2; v.wa = in[13:11]; v.din = {5'b0, in[10:0]};
        end else if (in[15:14] == 2'b01) begin
            n = int'(in[2:0]) + 1;
            c = 0;
            for (int k = 2; k <= n + 1; k++) c += int'(mask[k]);
            v.wr_n = n; v.dc = n + 2; v.carry = 4'(c > 8 ? 8 : c);
            v.sel = 1'b1; v.op = in[13:12]; v.ra = in[11:9]; v.rb = in[8:6]; v.wa = in[5:3];
        end
        return v;
    endfunction

    // Called at a negedge with the DUT idle; the instruction is accepted at the next edge.
    task automatic run(input vec_t v, input bit keep);
        logic w;
        instr = v.instr;
        instr_valid = 1'b1;
        cout = 1'b0;
        for (int k = 1; k <= v.dc + 1; k++) begin
            @(negedge clk);
            if (!keep || k == v.dc + 1) instr_valid = 1'b0;
            w = k <= v.wr_n;
            chk("wr", 16'(wr), 16'(w));
            chk("sel", 16'(sel), 16'(w ? v.sel : 1'b0));
            chk("op", 16'(op), 16'(w ? v.op : 2'd0));
            chk("rd_addr_a", 16'(rd_addr_a), 16'(w ? v.ra : 3'd0));
            chk("rd_addr_b", 16'(rd_addr_b), 16'(w ? v.rb : 3'd0));
            chk("wr_addr", 16'(wr_addr), 16'(w ? v.wa : 3'd0));
            chk("d_in", d_in, w ? v.din : 16'd0);
            chk("done", 16'(done), 16'(k == v.dc));
            chk("busy", 16'(busy), 16'(k <= v.dc));
            chk("instr_ready", 16'(instr_ready), 16'(k > v.dc));
            if (k >= v.dc) chk("carry_cnt", 16'(carry_cnt), 16'(v.carry));
            cout = v.mask[k];
        end
        cout = 1'b0;
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        tbl[0] = '{16'h1D55, 16'h0000, 1, 2, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd3, 16'h0555};
        tbl[1] = '{16'h6288, 16'h0004, 1, 3, 4'd1, 1'b1, 2'd2, 3'd1, 3'd2, 3'd1, 16'h0000};
        tbl[2] = '{16'h4217, 16'h0214, 8, 10, 4'd3, 1'b1, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0000};
        tbl[3] = '{16'h8000, 16'hFFFF, 0, 1, 4'd0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000};
        tbl[4] = '{16'h7BBF, 16'hFFFF, 8, 10, 4'd8, 1'b1, 2'd3, 3'd5, 3'd6, 3'd7, 16'h0000};
        tbl[5] = '{16'h4217, 16'h0402, 8, 10, 4'd0, 1'b1, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0000};

        instr = 16'h1D55;
        instr_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wr", 16'(wr), 16'd0);
            chk("rst_ready", 16'(instr_ready), 16'd1);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_carry", 16'(carry_cnt), 16'd0);
            chk("rst_addr", 16'(wr_addr), 16'd0);
        end
        reset = 1'b1;
        run(tbl[0], 1'b0);

        for (int i = 1; i < 6; i++) run(tbl[i], i == 2);

        // reset pulsed during cycle 4 of an eight-iteration repeat
        instr = 16'h4217;
        instr_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            chk("mid_wr_pre", 16'(wr), 16'd1);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_wr_rst", 16'(wr), 16'd0);
        chk("mid_ready_rst", 16'(instr_ready), 16'd1);
        chk("mid_busy_rst", 16'(busy), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("mid_wr_post", 16'(wr), 16'd0);
            chk("mid_done_post", 16'(done), 16'd0);
            chk("mid_ready_post", 16'(instr_ready), 16'd1);
        end

        for (int i = 0; i < 60; i++) begin
            rv = model(16'($urandom), 16'($urandom));
            run(rv, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
